// File: rtl/mul43_arbiter.sv
// Two requesters share one 4x3 unsigned multiplier through a round-robin arbiter;
// the product is registered and tagged with its owner. Define MUL43_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module mul43_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0_VALID,
    input  logic [3:0]       REQ0_X,
    input  logic [2:0]       REQ0_Y,
    output logic             REQ0_READY,
    input  logic             REQ1_VALID,
    input  logic [3:0]       REQ1_X,
    input  logic [2:0]       REQ1_Y,
    output logic             REQ1_READY,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic             RSP_ID,
    output logic [6:0]       RSP_P,
    output logic [CNT_W-1:0] GNT_CNT0,
    output logic [CNT_W-1:0] GNT_CNT1
);

    localparam int unsigned P_W = 7;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             id_q, id_d;
    logic [P_W-1:0]   p_q, p_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             slot_free;
    logic             pick1;
    logic             acc;
    logic [3:0]       x_mux;
    logic [2:0]       y_mux;
    logic [P_W-1:0]   prod;

    // State register; reset forces last=1 so requester 0 wins the first contention.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_EMPTY;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            p_q     <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            p_q     <= p_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    // Arbitration, operand mux, multiplier and response next-state.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        p_d        = p_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;

        slot_free = (state_q == ST_EMPTY) || RSP_READY;
`ifdef MUL43_ARB_FIXED_PRIO_EN
        pick1 = REQ1_VALID && !REQ0_VALID;
`else
        pick1 = REQ1_VALID && (!REQ0_VALID || !last_q);
`endif
        if (!RST && slot_free) begin
            REQ1_READY = pick1;
            REQ0_READY = REQ0_VALID && !pick1;
        end
        acc = REQ0_READY || REQ1_READY;

        x_mux = REQ1_READY ? REQ1_X : REQ0_X;
        y_mux = REQ1_READY ? REQ1_Y : REQ0_Y;
        prod  = P_W'(x_mux) * P_W'(y_mux);

        if (acc) begin
            p_d    = prod;
            id_d   = REQ1_READY;
            last_d = REQ1_READY;
            if (REQ1_READY) begin
                if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
                if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
            end
        end

        case (state_q)
            ST_EMPTY: if (acc) state_d = ST_FULL;
            ST_FULL:  if (!acc && RSP_READY) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    assign RSP_VALID = (state_q == ST_FULL);
    assign RSP_ID    = id_q;
    assign RSP_P     = p_q;
    assign GNT_CNT0  = cnt0_q;
    assign GNT_CNT1  = cnt1_q;

endmodule
